// File: rtl/fetch_ctrl_pkg.sv
// Shared constants and types for the instruction-fetch front end.
package fetch_ctrl_pkg;

    localparam int unsigned     XLEN             = 32;
    localparam logic [XLEN-1:0] INSTR_NOP        = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_ctrl_fifo.sv
// Synchronous FIFO with flush; empty reads return zero so the head is never X.
module fetch_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       wdata_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       rdata_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   empty_o,
    output logic                   full_o
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [PW:0]      cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == (PW+1)'(DEPTH));
    assign count_o = cnt_q;
    assign rdata_o = empty_o ? '0 : mem_q[rd_q];
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (flush_i) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (do_push) wr_d = wr_q + PW'(1);
            if (do_pop)  rd_d = rd_q + PW'(1);
            cnt_d = cnt_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) mem_q[wr_q] <= wdata_i;
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch front end: owns the fetch PC, issues req/gnt/rvalid fetches, buffers
// returned instructions for decode and drops wrong-path responses on redirect.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int unsigned     FIFO_DEPTH = 2
) (
    input  logic            CPU_CLK,
    input  logic            CPU_RST_N,
    input  logic            RedirectE,
    input  logic [XLEN-1:0] RedirectPC,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            InstrValidD,
    output logic [XLEN-1:0] InstrD,
    output logic [XLEN-1:0] PCD,
    input  logic            ReadyD
);

    localparam int unsigned CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0] DEPTH_LIM = (CW+1)'(FIFO_DEPTH);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [CW-1:0]   out_q, out_d;
    logic [CW-1:0]   drop_q, drop_d;

    logic            grant, rsp, keep, deq;
    logic [CW:0]     credit_used;
    logic [CW-1:0]   ibuf_count, pcq_count;
    logic            ibuf_empty, ibuf_full, pcq_empty, pcq_full;
    fetch_entry_t    ibuf_wdata, ibuf_head;
    logic [XLEN-1:0] pcq_head;

    assign deq = !ibuf_empty && ReadyD;
    // A dequeue frees its slot in the same cycle, so ReadyD=1 sustains one fetch per cycle.
    assign credit_used = {1'b0, out_q} + {1'b0, ibuf_count} - (CW+1)'(deq);
    assign imem_req    = CPU_RST_N && !RedirectE && (credit_used < DEPTH_LIM);
    assign imem_addr   = pc_q;
    assign grant       = imem_req && imem_gnt;

    assign rsp  = imem_rvalid && (out_q != '0);
    assign keep = rsp && (drop_q == '0) && !RedirectE;

    always_comb begin
        pc_d   = pc_q;
        out_d  = out_q + CW'(grant) - CW'(rsp);
        drop_d = drop_q;
        if (RedirectE) begin
            pc_d   = word_align(RedirectPC);
            drop_d = out_d;
        end else begin
            if (grant)                    pc_d   = pc_q + 32'd4;
            if (rsp && (drop_q != '0))    drop_d = drop_q - CW'(1);
        end
    end

    always_ff @(posedge CPU_CLK or negedge CPU_RST_N) begin
        if (!CPU_RST_N) begin
            pc_q   <= RESET_PC;
            out_q  <= '0;
            drop_q <= '0;
        end else begin
            pc_q   <= pc_d;
            out_q  <= out_d;
            drop_q <= drop_d;
        end
    end

    fetch_fifo #(
        .WIDTH (XLEN),
        .DEPTH (FIFO_DEPTH)
    ) u_pc_queue (
        .clk_i   (CPU_CLK),
        .rst_ni  (CPU_RST_N),
        .flush_i (RedirectE),
        .push_i  (grant),
        .wdata_i (pc_q),
        .pop_i   (keep),
        .rdata_o (pcq_head),
        .count_o (pcq_count),
        .empty_o (pcq_empty),
        .full_o  (pcq_full)
    );

    assign ibuf_wdata = '{pc: pcq_head, instr: imem_rdata};

    fetch_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_instr_buf (
        .clk_i   (CPU_CLK),
        .rst_ni  (CPU_RST_N),
        .flush_i (RedirectE),
        .push_i  (keep),
        .wdata_i (ibuf_wdata),
        .pop_i   (deq),
        .rdata_o (ibuf_head),
        .count_o (ibuf_count),
        .empty_o (ibuf_empty),
        .full_o  (ibuf_full)
    );

    assign InstrValidD = !ibuf_empty;
    assign InstrD      = ibuf_head.instr;
    assign PCD         = ibuf_head.pc;

    a_no_orphan_rsp: assert property (@(posedge CPU_CLK) disable iff (!CPU_RST_N)
        !(imem_rvalid && (out_q == '0)));

    a_inflight_accounted: assert property (@(posedge CPU_CLK) disable iff (!CPU_RST_N)
        out_q == pcq_count + drop_q);

    a_no_overflow: assert property (@(posedge CPU_CLK) disable iff (!CPU_RST_N)
        !((keep && ibuf_full && !deq) || (grant && pcq_full && !keep) || (keep && pcq_empty)));

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: vector table, directed redirect/reset sequences and
// randomized traffic checked against a queue-based model of the fetch pipeline.
module tb_fetch_ctrl;
    import fetch_ctrl_pkg::*;

    localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;
    localparam int          DEPTH  = 2;

    logic        CPU_CLK, CPU_RST_N;
    logic        RedirectE, imem_req, imem_gnt, imem_rvalid, InstrValidD, ReadyD;
    logic [31:0] RedirectPC, imem_addr, imem_rdata, InstrD, PCD;

    fetch_ctrl #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
        .CPU_CLK(CPU_CLK), .CPU_RST_N(CPU_RST_N), .RedirectE(RedirectE), .RedirectPC(RedirectPC),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
        .imem_rdata(imem_rdata), .InstrValidD(InstrValidD), .InstrD(InstrD), .PCD(PCD), .ReadyD(ReadyD)
    );

    initial begin
        CPU_CLK = 1'b0;
        forever #5 CPU_CLK = ~CPU_CLK;
    end

    typedef struct { logic [31:0] pc; bit stale; } infl_t;
    typedef struct { logic [31:0] addr; int unsigned due; } mreq_t;
    typedef struct { bit rdy; bit e_req; logic [31:0] e_addr; bit e_valid; logic [31:0] e_pc; } vec_t;

    infl_t        infl[$];   // fetches the model believes are in flight
    fetch_entry_t bufq[$];   // instructions waiting for decode
    mreq_t        mq[$];     // memory side: granted requests awaiting response
    logic [31:0]  mpc;
    int unsigned  lat, cyc;
    int           n_checks, n_fail;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return INSTR_NOP ^ {a[15:0], a[31:16]} ^ 32'h5A5A_0000;
    endfunction

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: expected event did not occur (cycle %0d)", name, cyc);
    endfunction

    function automatic bit model_req();
        int used;
        used = infl.size() + bufq.size() - (((bufq.size() != 0) && ReadyD) ? 1 : 0);
        return !RedirectE && (used < DEPTH);
    endfunction

    task automatic drive(input bit redir, input logic [31:0] rpc, input bit gnt, input bit rdy);
        RedirectE  = redir;
        RedirectPC = rpc;
        imem_gnt   = gnt;
        ReadyD     = rdy;
        if (mq.size() != 0 && mq[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(mq[0].addr);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'hDEAD_BEEF;
        end
    endtask

    task automatic model_check();
        chk("imem_req", 32'(imem_req), 32'(model_req()));
        chk("imem_addr", imem_addr, mpc);
        chk("InstrValidD", 32'(InstrValidD), 32'(bufq.size() != 0));
        if (bufq.size() != 0) begin
            chk("PCD", PCD, bufq[0].pc);
            chk("InstrD", InstrD, bufq[0].instr);
        end
    endtask

    task automatic advance();
        bit    deq, greq;
        infl_t e;
        deq  = (bufq.size() != 0) && ReadyD;
        greq = model_req() && imem_gnt;
        if (imem_req && imem_gnt) mq.push_back('{addr: imem_addr, due: cyc + lat});
        if (imem_rvalid) mq.delete(0);
        if (deq) bufq.delete(0);
        if (imem_rvalid && infl.size() != 0) begin
            e = infl.pop_front();
            if (!e.stale && !RedirectE) bufq.push_back('{pc: e.pc, instr: mem_word(e.pc)});
        end
        if (greq) begin
            infl.push_back('{pc: mpc, stale: 1'b0});
            mpc = mpc + 32'd4;
        end
        if (RedirectE) begin
            foreach (infl[i]) infl[i].stale = 1'b1;
            bufq.delete();
            mpc = {RedirectPC[31:2], 2'b00};
        end
        @(posedge CPU_CLK);
        @(negedge CPU_CLK);
        cyc++;
    endtask

    task automatic step(input bit redir, input logic [31:0] rpc, input bit gnt, input bit rdy);
        drive(redir, rpc, gnt, rdy);
        #1;
        model_check();
        advance();
    endtask

    task automatic do_reset();
        CPU_RST_N   = 1'b0;
        RedirectE   = 1'b0;
        RedirectPC  = '0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        ReadyD      = 1'b0;
        mq.delete();
        infl.delete();
        bufq.delete();
        mpc = RST_PC;
        #1;
        chk("reset imem_req", 32'(imem_req), 32'd0);
        chk("reset imem_addr", imem_addr, RST_PC);
        chk("reset InstrValidD", 32'(InstrValidD), 32'd0);
        chk("reset InstrD", InstrD, 32'd0);
        chk("reset PCD", PCD, 32'd0);
        @(negedge CPU_CLK);
        @(negedge CPU_CLK);
        CPU_RST_N = 1'b1;
    endtask

    task automatic wait_first_pc(input string name, input logic [31:0] exp_pc);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            drive(1'b0, '0, 1'b1, 1'b1);
            #1;
            if (InstrValidD) begin
                found = 1'b1;
                chk(name, PCD, exp_pc);
            end
            model_check();
            advance();
        end
        if (!found) fail_now(name);
    endtask

    vec_t vt[12];

    initial begin
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        lat      = 1;
        vt[0]  = '{1'b1, 1'b1, 32'hFFFF_FFF8, 1'b0, 32'h0};
        vt[1]  = '{1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0};
        vt[2]  = '{1'b1, 1'b1, 32'h0000_0000, 1'b1, 32'hFFFF_FFF8};
        vt[3]  = '{1'b1, 1'b1, 32'h0000_0004, 1'b1, 32'hFFFF_FFFC};
        for (int i = 4; i <= 8; i++) vt[i] = '{1'b0, 1'b0, 32'h0000_0008, 1'b1, 32'h0000_0000};
        vt[9]  = '{1'b1, 1'b1, 32'h0000_0008, 1'b1, 32'h0000_0000};
        vt[10] = '{1'b1, 1'b1, 32'h0000_000C, 1'b1, 32'h0000_0004};
        vt[11] = '{1'b1, 1'b1, 32'h0000_0010, 1'b1, 32'h0000_0008};

        @(negedge CPU_CLK);
        do_reset();
        lat = 1;
        for (int i = 0; i < 12; i++) begin
            drive(1'b0, '0, 1'b1, vt[i].rdy);
            #1;
            chk($sformatf("vec%0d imem_req", i), 32'(imem_req), 32'(vt[i].e_req));
            chk($sformatf("vec%0d imem_addr", i), imem_addr, vt[i].e_addr);
            chk($sformatf("vec%0d InstrValidD", i), 32'(InstrValidD), 32'(vt[i].e_valid));
            if (vt[i].e_valid) begin
                chk($sformatf("vec%0d PCD", i), PCD, vt[i].e_pc);
                chk($sformatf("vec%0d InstrD", i), InstrD, mem_word(vt[i].e_pc));
            end
            advance();
        end

        // Redirect with two fetches outstanding; both responses must be discarded.
        do_reset();
        lat = 3;
        step(1'b0, '0, 1'b1, 1'b1);
        step(1'b0, '0, 1'b1, 1'b1);
        step(1'b1, 32'h0000_0103, 1'b1, 1'b1);
        drive(1'b0, '0, 1'b1, 1'b1);
        #1;
        chk("redirect target addr", imem_addr, 32'h0000_0100);
        model_check();
        advance();
        wait_first_pc("first PCD after redirect", 32'h0000_0100);

        // Redirect in the same cycle as a response, 3-cycle memory.
        do_reset();
        lat = 3;
        step(1'b0, '0, 1'b1, 1'b1);
        step(1'b0, '0, 1'b1, 1'b1);
        step(1'b0, '0, 1'b1, 1'b1);
        drive(1'b1, 32'h0000_0200, 1'b1, 1'b1);
        #1;
        chk("rvalid present at redirect", 32'(imem_rvalid && !imem_req), 32'd1);
        model_check();
        advance();
        wait_first_pc("first PCD after redirect+rvalid", 32'h0000_0200);

        // Asynchronous reset with a buffered instruction and a fetch in flight.
        do_reset();
        lat = 2;
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0);
        chk("valid before async reset", 32'(InstrValidD), 32'd1);
        #3;
        do_reset();
        drive(1'b0, '0, 1'b1, 1'b1);
        #1;
        chk("restart imem_req", 32'(imem_req), 32'd1);
        chk("restart imem_addr", imem_addr, RST_PC);
        advance();

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            if (c % 100 == 0) lat = $urandom_range(1, 3);
            step($urandom_range(0, 15) == 0, $urandom, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 9) < 7);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
